// File: rtl/uart_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_bus_bridge
// Purpose  : Turns framed command packets from a UART receiver byte stream
//            into single-word host bus transactions. Status and read data
//            are returned as bytes to the UART transmitter. This gives a host
//            PC peek/poke access to memory and peripherals.
//
//            Write packet : CmdWrite A0 A1 A2 A3 D0 D1 D2 D3 -> ACK|NAK
//            Read packet  : CmdRead  A0 A1 A2 A3             -> ACK|NAK D0..D3
//            Other opcode :                                  -> NAK
//            All multi-byte fields are little-endian.
//
// Ports    : clk_i, rst_ni          clock, async active-low reset
//            rx_valid_i/rx_data_i   received byte stream (no backpressure)
//            tx_valid_o/tx_data_o/  response byte stream
//            tx_ready_i
//            host_*                 single-word host bus master
//            drop_o                 pulse: rx byte discarded while busy
//
// Revision : 1.0  initial release
// ============================================================================
module uart_bus_bridge #(
  parameter int unsigned TimeoutCycles = 10_000,  // minimum 2
  parameter logic [7:0]  CmdWrite      = 8'h57,
  parameter logic [7:0]  CmdRead       = 8'h52
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // receive byte stream
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  // transmit byte stream
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  // host bus
  output logic        host_req_o,
  input  logic        host_gnt_i,
  output logic [31:0] host_addr_o,
  output logic        host_we_o,
  output logic [3:0]  host_be_o,
  output logic [31:0] host_wdata_o,
  input  logic        host_rvalid_i,
  input  logic [31:0] host_rdata_i,
  input  logic        host_err_i,
  // status
  output logic        drop_o
);

  localparam int unsigned    TMO_W    = $clog2(TimeoutCycles);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TimeoutCycles - 1);
  localparam logic [7:0]     ACK_BYTE = 8'h06;
  localparam logic [7:0]     NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_DATA     = 3'd2,
    ST_BUS_REQ  = 3'd3,
    ST_BUS_WAIT = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

  state_e             r_state;
  state_e             w_state_next;

  logic [1:0]         r_byte_cnt;
  logic [2:0]         r_resp_cnt;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_is_write;
  logic               r_is_read;
  logic               r_err;
  logic               r_drop;

  logic               w_collecting;
  logic               w_tmo_hit;
  logic               w_tx_hs;
  logic [2:0]         w_resp_last;
  logic               w_busy;

  // Timeout only matters while a packet is partially received.
  assign w_collecting = (r_state == ST_ADDR) || (r_state == ST_DATA);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign w_tmo_hit    = w_collecting && !rx_valid_i && (r_tmo_cnt == TMO_LAST);
  assign w_tx_hs      = tx_valid_o && tx_ready_i;
  // Unknown opcodes clear r_is_read, so they share the single-byte path.
  assign w_resp_last  = r_is_read ? 3'd4 : 3'd0;
  assign w_busy       = (r_state == ST_BUS_REQ) || (r_state == ST_BUS_WAIT) ||
                        (r_state == ST_RESP);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (rx_valid_i) begin
          if ((rx_data_i == CmdWrite) || (rx_data_i == CmdRead)) begin
            w_state_next = ST_ADDR;
          end else begin
            w_state_next = ST_RESP;
          end
        end
      end
      ST_ADDR: begin
        if (rx_valid_i && (r_byte_cnt == 2'd3)) begin
          w_state_next = r_is_write ? ST_DATA : ST_BUS_REQ;
        end else if (w_tmo_hit) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (rx_valid_i && (r_byte_cnt == 2'd3)) begin
          w_state_next = ST_BUS_REQ;
        end else if (w_tmo_hit) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_BUS_REQ: begin
        if (host_gnt_i) begin
          w_state_next = ST_BUS_WAIT;
        end
      end
      ST_BUS_WAIT: begin
        if (host_rvalid_i) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_tx_hs && (r_resp_cnt == w_resp_last)) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_byte_cnt <= 2'd0;
      r_resp_cnt <= 3'd0;
      r_tmo_cnt  <= '0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      r_is_write <= 1'b0;
      r_is_read  <= 1'b0;
      r_err      <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_drop <= rx_valid_i && w_busy;

      // Counter restarts on every accepted byte and idles outside collection.
      if (w_collecting && !rx_valid_i) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
        r_tmo_cnt <= '0;
      end

      case (r_state)
        ST_IDLE: begin
          if (rx_valid_i) begin
            r_is_write <= (rx_data_i == CmdWrite);
            r_is_read  <= (rx_data_i == CmdRead);
            r_err      <= (rx_data_i != CmdWrite) && (rx_data_i != CmdRead);
            r_byte_cnt <= 2'd0;
            r_resp_cnt <= 3'd0;
            r_rdata    <= 32'h0;
          end
        end
        ST_ADDR: begin
          if (rx_valid_i) begin
            // LSB first: after four bytes A0 sits in [7:0].
            r_addr     <= {rx_data_i, r_addr[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        ST_DATA: begin
          if (rx_valid_i) begin
            r_wdata    <= {rx_data_i, r_wdata[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        ST_BUS_WAIT: begin
          if (host_rvalid_i) begin
            r_err   <= host_err_i;
            r_rdata <= (host_err_i || !r_is_read) ? 32'h0 : host_rdata_i;
          end
        end
        ST_RESP: begin
          if (w_tx_hs) begin
            r_resp_cnt <= r_resp_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Response byte selection
  // --------------------------------------------------------------------------
  always_comb begin
    tx_data_o = 8'h00;
    if (r_state == ST_RESP) begin
      case (r_resp_cnt)
        3'd0:    tx_data_o = r_err ? NAK_BYTE : ACK_BYTE;
        3'd1:    tx_data_o = r_rdata[7:0];
        3'd2:    tx_data_o = r_rdata[15:8];
        3'd3:    tx_data_o = r_rdata[23:16];
        3'd4:    tx_data_o = r_rdata[31:24];
        default: tx_data_o = 8'h00;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign tx_valid_o   = (r_state == ST_RESP);
  assign host_req_o   = (r_state == ST_BUS_REQ);
  // Word aligned regardless of the low bits of A0.
  assign host_addr_o  = r_addr & 32'hFFFF_FFFC;
  assign host_we_o    = r_is_write;
  assign host_be_o    = 4'hF;
  assign host_wdata_o = r_wdata;
  assign drop_o       = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_bus_bridge
// Purpose  : Directed self-checking bench for uart_bus_bridge. Drives packets
//            byte by byte, models the host bus slave and drains responses.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_bus_bridge;

  localparam int unsigned T = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i = 1'b0;
  logic        host_req_o;
  logic        host_gnt_i = 1'b0;
  logic [31:0] host_addr_o;
  logic        host_we_o;
  logic [3:0]  host_be_o;
  logic [31:0] host_wdata_o;
  logic        host_rvalid_i = 1'b0;
  logic [31:0] host_rdata_i = 32'h0;
  logic        host_err_i = 1'b0;
  logic        drop_o;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  uart_bus_bridge #(
    .TimeoutCycles (T),
    .CmdWrite      (8'h57),
    .CmdRead       (8'h52)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rx_valid_i    (rx_valid_i),
    .rx_data_i     (rx_data_i),
    .tx_valid_o    (tx_valid_o),
    .tx_data_o     (tx_data_o),
    .tx_ready_i    (tx_ready_i),
    .host_req_o    (host_req_o),
    .host_gnt_i    (host_gnt_i),
    .host_addr_o   (host_addr_o),
    .host_we_o     (host_we_o),
    .host_be_o     (host_be_o),
    .host_wdata_o  (host_wdata_o),
    .host_rvalid_i (host_rvalid_i),
    .host_rdata_i  (host_rdata_i),
    .host_err_i    (host_err_i),
    .drop_o        (drop_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the byte is sampled on the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
  endtask

  // Slave: wait for request, grant after lat cycles, respond next cycle.
  task automatic host_txn(input int lat, input logic err, input logic [31:0] rd,
                          input string tag);
    int n = 0;
    while (host_req_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, " req"}, 32'(host_req_o), 32'd1);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk_i);
      chk({tag, " req held"}, 32'(host_req_o), 32'd1);
    end
    host_gnt_i = 1'b1;
    @(negedge clk_i);
    host_gnt_i = 1'b0;
    chk({tag, " req drop"}, 32'(host_req_o), 32'd0);
    host_rvalid_i = 1'b1;
    host_err_i    = err;
    host_rdata_i  = rd;
    @(negedge clk_i);
    host_rvalid_i = 1'b0;
    host_err_i    = 1'b0;
    host_rdata_i  = 32'h0;
  endtask

  // Wait for a response byte, compare it, then handshake it.
  task automatic recv(input logic [7:0] exp, input string tag);
    int n = 0;
    while (tx_valid_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, " valid"}, 32'(tx_valid_o), 32'd1);
    chk({tag, " data"}, 32'(tx_data_o), 32'(exp));
    tx_ready_i = 1'b1;
    @(negedge clk_i);
    tx_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset values ----------------
    repeat (2) @(negedge clk_i);
    chk("rst tx_valid", 32'(tx_valid_o), 32'd0);
    chk("rst tx_data", 32'(tx_data_o), 32'd0);
    chk("rst req", 32'(host_req_o), 32'd0);
    chk("rst we", 32'(host_we_o), 32'd0);
    chk("rst addr", host_addr_o, 32'd0);
    chk("rst wdata", host_wdata_o, 32'd0);
    chk("rst drop", 32'(drop_o), 32'd0);
    chk("rst be", 32'(host_be_o), 32'hF);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // ---------------- write ----------------
    send_byte(8'h57); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h20); send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD);
    chk("wr req before last", 32'(host_req_o), 32'd0);
    send_byte(8'hDE);
    chk("wr req rise", 32'(host_req_o), 32'd1);
    chk("wr addr", host_addr_o, 32'h2000_0010);
    chk("wr we", 32'(host_we_o), 32'd1);
    chk("wr wdata", host_wdata_o, 32'hDEAD_BEEF);
    chk("wr be", 32'(host_be_o), 32'hF);
    host_txn(3, 1'b0, 32'h0, "wr");
    chk("wr addr held", host_addr_o, 32'h2000_0010);
    chk("wr tx rise", 32'(tx_valid_o), 32'd1);
    recv(8'h06, "wr ack");
    chk("wr tx done", 32'(tx_valid_o), 32'd0);

    // ---------------- read with tx_ready 1-0-0-1 ----------------
    send_byte(8'h52); send_byte(8'h04); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h10);
    chk("rd addr", host_addr_o, 32'h1000_0004);
    chk("rd we", 32'(host_we_o), 32'd0);
    host_txn(0, 1'b0, 32'h1234_5678, "rd");
    recv(8'h06, "rd ack");
    chk("rd b0 now", 32'(tx_data_o), 32'h78);
    @(negedge clk_i);
    chk("rd b0 hold1", 32'(tx_data_o), 32'h78);
    chk("rd b0 valid", 32'(tx_valid_o), 32'd1);
    @(negedge clk_i);
    chk("rd b0 hold2", 32'(tx_data_o), 32'h78);
    recv(8'h78, "rd b0");
    recv(8'h56, "rd b1");
    recv(8'h34, "rd b2");
    recv(8'h12, "rd b3");
    chk("rd tx done", 32'(tx_valid_o), 32'd0);

    // ---------------- read error ----------------
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h30);
    host_txn(1, 1'b1, 32'hAABB_CCDD, "er");
    recv(8'h15, "er nak");
    recv(8'h00, "er b0");
    recv(8'h00, "er b1");
    recv(8'h00, "er b2");
    recv(8'h00, "er b3");
    chk("er tx done", 32'(tx_valid_o), 32'd0);

    // ---------------- unknown opcode ----------------
    send_byte(8'h41);
    chk("unk req", 32'(host_req_o), 32'd0);
    chk("unk tx rise", 32'(tx_valid_o), 32'd1);
    recv(8'h15, "unk nak");
    chk("unk tx done", 32'(tx_valid_o), 32'd0);
    chk("unk req after", 32'(host_req_o), 32'd0);

    // ---------------- timeout, then a normal read ----------------
    send_byte(8'h57); send_byte(8'h10); send_byte(8'h00);
    repeat (T + 2) @(negedge clk_i);
    chk("tmo no req", 32'(host_req_o), 32'd0);
    chk("tmo no tx", 32'(tx_valid_o), 32'd0);
    send_byte(8'h52); send_byte(8'h04); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h10);
    chk("tmo rd req", 32'(host_req_o), 32'd1);
    chk("tmo rd addr", host_addr_o, 32'h1000_0004);
    chk("tmo rd we", 32'(host_we_o), 32'd0);
    host_txn(0, 1'b0, 32'hCAFE_F00D, "tmo rd");
    recv(8'h06, "tmo ack");
    recv(8'h0D, "tmo b0");
    recv(8'hF0, "tmo b1");
    recv(8'hFE, "tmo b2");
    recv(8'hCA, "tmo b3");

    // ---------------- byte on the timeout edge is accepted ----------------
    send_byte(8'h52); send_byte(8'h08); send_byte(8'h00);
    repeat (T - 1) @(negedge clk_i);
    send_byte(8'h00);
    send_byte(8'h20);
    chk("edge req", 32'(host_req_o), 32'd1);
    chk("edge addr", host_addr_o, 32'h2000_0008);
    host_txn(0, 1'b0, 32'h0, "edge");
    recv(8'h06, "edge ack");
    recv(8'h00, "edge b0");
    recv(8'h00, "edge b1");
    recv(8'h00, "edge b2");
    recv(8'h00, "edge b3");

    // ---------------- overrun in BUS_WAIT, unaligned address ----------------
    send_byte(8'h52); send_byte(8'h13); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00);
    chk("ovr addr aligned", host_addr_o, 32'h0000_0010);
    host_gnt_i = 1'b1;
    @(negedge clk_i);
    host_gnt_i = 1'b0;
    chk("ovr drop pre", 32'(drop_o), 32'd0);
    send_byte(8'hAA);
    chk("ovr drop pulse", 32'(drop_o), 32'd1);
    host_rvalid_i = 1'b1;
    host_rdata_i  = 32'h1122_3344;
    @(negedge clk_i);
    host_rvalid_i = 1'b0;
    host_rdata_i  = 32'h0;
    chk("ovr drop end", 32'(drop_o), 32'd0);
    recv(8'h06, "ovr ack");
    recv(8'h44, "ovr b0");
    recv(8'h33, "ovr b1");
    recv(8'h22, "ovr b2");
    recv(8'h11, "ovr b3");
    chk("ovr tx done", 32'(tx_valid_o), 32'd0);

    // ---------------- reset during BUS_REQ ----------------
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
    send_byte(8'h12);
    chk("mrst req before", 32'(host_req_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mrst req", 32'(host_req_o), 32'd0);
    chk("mrst addr", host_addr_o, 32'd0);
    chk("mrst we", 32'(host_we_o), 32'd0);
    chk("mrst wdata", host_wdata_o, 32'd0);
    chk("mrst tx_valid", 32'(tx_valid_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    send_byte(8'h57); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00);
    chk("post addr", host_addr_o, 32'h0000_0040);
    chk("post wdata", host_wdata_o, 32'h0000_0001);
    chk("post we", 32'(host_we_o), 32'd1);
    host_txn(2, 1'b0, 32'h0, "post");
    recv(8'h06, "post ack");
    chk("post tx done", 32'(tx_valid_o), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
